// File: rtl/vdp_blend_pkg.sv
// Shared definitions for the VDP blend scheduler slice.
//
// Contents:
//   state_t             scheduler FSM encoding (IDLE / ISSUE / WAIT / DONE)
//   ALPHA_OPAQUE        alpha nibble stamped on every composited result
//   ARGB field layout   widths and offsets of the ARGB4444 colour word
//   argb_alpha/argb_rgb slice helpers, make_opaque builds {F, rgb12}
package vdp_blend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ARGB_W    = 16;
    localparam int ALPHA_W   = 4;
    localparam int RGB_W     = 12;
    localparam int ALPHA_LSB = 12;
    localparam int RGB_LSB   = 0;

    localparam logic [ALPHA_W-1:0] ALPHA_OPAQUE = 4'hF;

    function automatic logic [ALPHA_W-1:0] argb_alpha(input logic [ARGB_W-1:0] c);
        return c[ALPHA_LSB +: ALPHA_W];
    endfunction

    function automatic logic [RGB_W-1:0] argb_rgb(input logic [ARGB_W-1:0] c);
        return c[RGB_LSB +: RGB_W];
    endfunction

    function automatic logic [ARGB_W-1:0] make_opaque(input logic [RGB_W-1:0] rgb);
        return {ALPHA_OPAQUE, rgb};
    endfunction

endpackage

// File: rtl/vdp_blend_scheduler_layer_picker.sv
// vdp_blend_layer_picker: combinational priority search for the next layer
// that needs a blender pass (enabled and alpha non-zero), lowest index first,
// considering only indices >= start.
//
// Ports:
//   enables   per-layer enable bits
//   alphas    per-layer alpha nibbles, layer i at [4*i+3:4*i]
//   start     first index eligible for selection (may equal LAYERS: none)
//   next_idx  selected layer index (0 when nothing found)
//   found     a qualifying layer exists at or above start
module vdp_blend_layer_picker
    import vdp_blend_pkg::*;
#(
    parameter int LAYERS = 4,
    parameter int IDX_W  = $clog2(LAYERS + 1)
) (
    input  logic [LAYERS-1:0]         enables,
    input  logic [ALPHA_W*LAYERS-1:0] alphas,
    input  logic [IDX_W-1:0]          start,
    output logic [IDX_W-1:0]          next_idx,
    output logic                      found
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if ((IDX_W'(i) >= start) && enables[i] &&
                (alphas[ALPHA_W*i +: ALPHA_W] != '0)) begin
                next_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdp_blend_scheduler.sv
// vdp_blend_scheduler: multi-pass compositing sequencer owning the shared
// fixed-latency alpha blender. Each accepted pixel stack is composited bottom
// (layer 0) to top, one blender pass per layer, each pass result becoming the
// opaque dest of the next pass. The final opaque colour is offered downstream.
//
// Build option: define BLEND_SKIP_TRANSPARENT_EN to skip layers that are
// disabled or fully transparent (alpha 0). Without it every layer gets a pass
// and latency is fixed at LAYERS*(BLEND_LATENCY+1)+1.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid / in_ready          stack handshake (in_ready high only in IDLE)
//   in_colors                    ARGB4444 per layer, layer i at [16*i+15:16*i]
//   in_enables                   per-layer enable
//   in_backdrop                  backdrop colour (alpha ignored)
//   blend_source_color           to blender, held for the whole pass
//   blend_source_layer_enabled   to blender, held for the whole pass
//   blend_dest_color             to blender, running accumulator
//   blend_output_color           from blender, [11:0] used
//   out_valid / out_ready        result handshake
//   out_color                    {4'hF, rgb12}
module vdp_blend_scheduler
    import vdp_blend_pkg::*;
#(
    parameter int LAYERS        = 4,
    parameter int BLEND_LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ARGB_W*LAYERS-1:0] in_colors,
    input  logic [LAYERS-1:0]        in_enables,
    input  logic [ARGB_W-1:0]        in_backdrop,
    output logic [ARGB_W-1:0]        blend_source_color,
    output logic                     blend_source_layer_enabled,
    output logic [ARGB_W-1:0]        blend_dest_color,
    input  logic [ARGB_W-1:0]        blend_output_color,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ARGB_W-1:0]        out_color
);

    // Index is one bit wider than strictly needed so "idx+1" can express
    // "past the top layer" without wrapping.
    localparam int IDX_W = $clog2(LAYERS + 1);
    localparam int CNT_W = $clog2(BLEND_LATENCY + 1);

    state_t                   state;
    logic [ARGB_W*LAYERS-1:0] colors_q;
    logic [LAYERS-1:0]        en_q;
    logic [IDX_W-1:0]         idx;
    logic [CNT_W-1:0]         cnt;
    logic [ARGB_W-1:0]        acc;

    logic [IDX_W-1:0]         first_idx;
    logic                     first_found;
    logic [IDX_W-1:0]         next_idx;
    logic                     next_found;
    logic [ARGB_W-1:0]        backdrop_opaque;
    logic [ARGB_W-1:0]        pass_result;

    function automatic logic [ARGB_W-1:0] pick_color(input logic [ARGB_W*LAYERS-1:0] c,
                                                     input logic [IDX_W-1:0] i);
        logic [ARGB_W*LAYERS-1:0] s;
        s = c >> (ARGB_W * i);
        return s[ARGB_W-1:0];
    endfunction

    function automatic logic pick_en(input logic [LAYERS-1:0] e, input logic [IDX_W-1:0] i);
        logic [LAYERS-1:0] s;
        s = e >> i;
        return s[0];
    endfunction

    assign in_ready        = (state == ST_IDLE);
    assign backdrop_opaque = make_opaque(argb_rgb(in_backdrop));
    assign pass_result     = make_opaque(argb_rgb(blend_output_color));

`ifdef BLEND_SKIP_TRANSPARENT_EN
    logic [ALPHA_W*LAYERS-1:0] in_alphas;
    logic [ALPHA_W*LAYERS-1:0] q_alphas;

    for (genvar g = 0; g < LAYERS; g++) begin : g_alpha
        assign in_alphas[ALPHA_W*g +: ALPHA_W] = argb_alpha(in_colors[ARGB_W*g +: ARGB_W]);
        assign q_alphas[ALPHA_W*g +: ALPHA_W]  = argb_alpha(colors_q[ARGB_W*g +: ARGB_W]);
    end

    // First pass is chosen straight from the offered stack so the accept
    // cycle can already load the blender inputs.
    vdp_blend_layer_picker #(.LAYERS(LAYERS), .IDX_W(IDX_W)) u_first_pick (
        .enables  (in_enables),
        .alphas   (in_alphas),
        .start    ('0),
        .next_idx (first_idx),
        .found    (first_found)
    );

    vdp_blend_layer_picker #(.LAYERS(LAYERS), .IDX_W(IDX_W)) u_next_pick (
        .enables  (en_q),
        .alphas   (q_alphas),
        .start    (idx + 1'b1),
        .next_idx (next_idx),
        .found    (next_found)
    );
`else
    assign first_idx   = '0;
    assign first_found = 1'b1;
    assign next_idx    = idx + 1'b1;
    assign next_found  = (idx != IDX_W'(LAYERS - 1));
`endif

    // Stack storage is plain data, captured on accept.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            colors_q <= in_colors;
            en_q     <= in_enables;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                      <= ST_IDLE;
            idx                        <= '0;
            cnt                        <= '0;
            acc                        <= '0;
            out_valid                  <= 1'b0;
            out_color                  <= '0;
            blend_source_color         <= '0;
            blend_source_layer_enabled <= 1'b0;
            blend_dest_color           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc <= backdrop_opaque;
                        idx <= first_idx;
                        if (first_found) begin
                            // Blender inputs are registered here so they are
                            // stable for the whole ISSUE+WAIT window.
                            blend_source_color         <= pick_color(in_colors, first_idx);
                            blend_source_layer_enabled <= pick_en(in_enables, first_idx);
                            blend_dest_color           <= backdrop_opaque;
                            state                      <= ST_ISSUE;
                        end else begin
                            out_color <= backdrop_opaque;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CNT_W'(BLEND_LATENCY - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        // Capture lands on ISSUE cycle + BLEND_LATENCY.
                        acc <= pass_result;
                        if (next_found) begin
                            idx                        <= next_idx;
                            blend_source_color         <= pick_color(colors_q, next_idx);
                            blend_source_layer_enabled <= pick_en(en_q, next_idx);
                            blend_dest_color           <= pass_result;
                            state                      <= ST_ISSUE;
                        end else begin
                            out_color <= pass_result;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_blend_scheduler.sv
// Testbench for vdp_blend_scheduler (LAYERS=4, BLEND_LATENCY=6).
// Includes a behavioural blender: colours sampled on the first edge, alpha and
// enable on the second, result visible after the sixth edge. Source weight is
// alpha+1 (0 for alpha 0 or disabled), dest weight 16-source, +8 rounding.
// Expected results below are hand-computed; latencies depend on whether
// BLEND_SKIP_TRANSPARENT_EN is defined.
module tb_vdp_blend_scheduler;

    localparam int LAYERS   = 4;
    localparam int BL       = 6;
    localparam int FULL_LAT = LAYERS * (BL + 1) + 1;
`ifdef BLEND_SKIP_TRANSPARENT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_colors;
    logic [3:0]  in_enables;
    logic [15:0] in_backdrop;
    logic [15:0] blend_source_color;
    logic        blend_source_layer_enabled;
    logic [15:0] blend_dest_color;
    logic [15:0] blend_output_color;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_color;

    always #5 clk = ~clk;

    vdp_blend_scheduler #(.LAYERS(LAYERS), .BLEND_LATENCY(BL)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .in_colors                  (in_colors),
        .in_enables                 (in_enables),
        .in_backdrop                (in_backdrop),
        .blend_source_color         (blend_source_color),
        .blend_source_layer_enabled (blend_source_layer_enabled),
        .blend_dest_color           (blend_dest_color),
        .blend_output_color         (blend_output_color),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_color                  (out_color)
    );

    // ---------------- blender model ----------------
    function automatic logic [11:0] blend_ref(input logic [15:0] s, input logic [15:0] d,
                                              input logic [3:0] a, input logic en);
        int          w;
        logic [11:0] r;
        w = (en && a != 4'd0) ? int'(a) + 1 : 0;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int sv;
            int dv;
            sv = int'(s[ch*4 +: 4]);
            dv = int'(d[ch*4 +: 4]);
            r[ch*4 +: 4] = 4'((sv * w + dv * (16 - w) + 8) >> 4);
        end
        return r;
    endfunction

    logic [15:0] bl_src1;
    logic [15:0] bl_dst1;
    logic [11:0] bl_pipe [2:6];

    always @(posedge clk) begin
        bl_src1    <= blend_source_color;
        bl_dst1    <= blend_dest_color;
        bl_pipe[2] <= blend_ref(bl_src1, bl_dst1, blend_source_color[15:12],
                                blend_source_layer_enabled);
        for (int k = 3; k <= 6; k++) bl_pipe[k] <= bl_pipe[k-1];
    end
    // Upper nibble deliberately non-F: the scheduler must force it.
    assign blend_output_color = {4'h5, bl_pipe[6]};

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [15:0] color;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_no = 0;

    initial forever begin
        @(posedge clk);
        edge_no++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t        e;
        logic        prev_ov;
        logic [15:0] held;
        int          lat;
        prev_ov = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (out_valid) begin
                    if (!prev_ov) begin
                        if (sbq.size() == 0) begin
                            check("unexpected_out_valid", 32'(out_valid), 32'd0);
                        end else begin
                            e   = sbq.pop_front();
                            lat = edge_no - e.acc_edge + 1;
                            check("out_color", 32'(out_color), 32'(e.color));
                            check("latency", lat, e.lat);
                            held = e.color;
                        end
                    end else begin
                        check("stall_out_color", 32'(out_color), 32'(held));
                    end
                    check("done_in_ready", 32'(in_ready), 32'd0);
                end
                prev_ov = out_valid;
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [63:0] colors, input logic [3:0] en,
                        input logic [15:0] backdrop, input logic [15:0] exp_color,
                        input int exp_lat, input bit push);
        int   n;
        exp_t e;
        @(negedge clk);
        in_colors   = colors;
        in_enables  = en;
        in_backdrop = backdrop;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        if (push) begin
            e.color    = exp_color;
            e.lat      = exp_lat;
            e.acc_edge = edge_no + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] snap_src;
        logic [15:0] snap_dst;
        logic        snap_en;
        int          n;

        in_valid    = 1'b0;
        in_colors   = '0;
        in_enables  = '0;
        in_backdrop = '0;
        out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_color", 32'(out_color), 32'd0);
        check("rst_blend_src", 32'(blend_source_color), 32'd0);
        check("rst_blend_en",  32'(blend_source_layer_enabled), 32'd0);
        check("rst_blend_dst", 32'(blend_dest_color), 32'd0);
        reset_n = 1'b1;

        // Opaque bottom layer over backdrop.
        send(64'h0000_0000_0000_FABC, 4'b0001, 16'h0123, 16'hFABC, SKIP ? 8 : FULL_LAT, 1'b1);
        wait_drain();

        // Half-alpha white/magenta over black: (15*8+8)>>4 = 8 per lit channel.
        send(64'h0000_0000_0000_7F0F, 4'b0001, 16'h0000, 16'hF808, SKIP ? 8 : FULL_LAT, 1'b1);
        wait_drain();

        // All layers disabled: result is the opaque backdrop.
        snap_src = blend_source_color;
        snap_dst = blend_dest_color;
        snap_en  = blend_source_layer_enabled;
        send(64'hF444_F333_F222_F111, 4'b0000, 16'h5456, 16'hF456, SKIP ? 1 : FULL_LAT, 1'b1);
        wait_drain();
`ifdef BLEND_SKIP_TRANSPARENT_EN
        check("skip_src_untouched", 32'(blend_source_color), 32'(snap_src));
        check("skip_dst_untouched", 32'(blend_dest_color), 32'(snap_dst));
        check("skip_en_untouched",  32'(blend_source_layer_enabled), 32'(snap_en));
`endif

        // Only layer2 qualifies (layer1 enabled but alpha 0).
        send(64'h8ABC_F321_0FFF_F111, 4'b0110, 16'h0A5A, 16'hF321, SKIP ? 8 : FULL_LAT, 1'b1);
        wait_drain();

        // Three real passes: 800 -> 404 -> (layer2 off) -> 703.
        send(64'h3F00_FFFF_7008_F800, 4'b1011, 16'h0000, 16'hF703, SKIP ? 22 : FULL_LAT, 1'b1);
        wait_drain();

        // Downstream stall for 10 cycles with in_valid pulses that must be ignored.
        out_ready = 1'b0;
        send(64'h0000_0000_0000_FABC, 4'b0001, 16'h0123, 16'hFABC, SKIP ? 8 : FULL_LAT, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid   = ~in_valid;
            in_colors  = 64'h1234_5678_9ABC_DEF0 ^ 64'(i);
            in_enables = 4'b1111;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_stall_out_valid", 32'(out_valid), 32'd0);
        check("post_stall_in_ready",  32'(in_ready), 32'd1);
        wait_drain();

        // Reset during the WAIT of pass 2 of 4.
        send(64'h2444_4333_8222_F111, 4'b1111, 16'h0FFF, 16'h0000, 0, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_rst_in_ready",  32'(in_ready), 32'd0);
        check("pre_rst_blend_src", 32'(blend_source_color), 32'h8222);
        check("pre_rst_blend_dst", 32'(blend_dest_color), 32'hF111);
        reset_n = 1'b0;
        sbq.delete();
        #1;
        check("mid_rst_in_ready",  32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_color", 32'(out_color), 32'd0);
        check("mid_rst_blend_src", 32'(blend_source_color), 32'd0);
        check("mid_rst_blend_en",  32'(blend_source_layer_enabled), 32'd0);
        check("mid_rst_blend_dst", 32'(blend_dest_color), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_in_ready",  32'(in_ready), 32'd1);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
        end

        // Fresh stack after reset; stale blender contents must not leak in.
        send(64'h0000_0000_0000_7F0F, 4'b0001, 16'h0000, 16'hF808, SKIP ? 8 : FULL_LAT, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
